// File: rtl/multi_mode_counter_gen2.sv
// Multi-mode up/down counter game: wins and losses are detected by boundary crossing.
// Scores accumulate until either limit is reached. All outputs come straight from flops.
module multi_mode_counter_gen2 #(
  parameter int WIDTH      = 4,
  parameter int SCORE_W    = 4,
  parameter int STEP_ALT   = 2,
  parameter int INIT_VAL   = 1,
  parameter int WIN_LIMIT  = 15,
  parameter int LOSE_LIMIT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_en,
  input  logic               i_init,
  input  logic [WIDTH-1:0]   i_load_value,
  input  logic [1:0]         i_mode,
  output logic [WIDTH-1:0]   o_count,
  output logic [SCORE_W-1:0] o_win_count,
  output logic [SCORE_W-1:0] o_lose_count,
  output logic               o_win_pulse,
  output logic               o_lose_pulse,
  output logic               o_gameover,
  output logic [1:0]         o_who
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH:0]     MAX_EXT  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]     ALT_EXT  = (WIDTH+1)'(STEP_ALT);
  localparam logic [WIDTH-1:0]   INIT_CNT = WIDTH'(INIT_VAL);
  localparam logic [SCORE_W-1:0] WIN_LIM  = SCORE_W'(WIN_LIMIT);
  localparam logic [SCORE_W-1:0] LOSE_LIM = SCORE_W'(LOSE_LIMIT);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_count;
  logic [SCORE_W-1:0] r_win_count;
  logic [SCORE_W-1:0] r_lose_count;
  logic               r_win_pulse;
  logic               r_lose_pulse;
  logic               r_gameover;
  logic [1:0]         r_who;

  logic [1:0]         w_state_nxt;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [SCORE_W-1:0] w_win_nxt;
  logic [SCORE_W-1:0] w_lose_nxt;
  logic               w_win_pulse_nxt;
  logic               w_lose_pulse_nxt;
  logic               w_gameover_nxt;
  logic [1:0]         w_who_nxt;

  logic [WIDTH:0]     w_step;
  logic [WIDTH:0]     w_sum;
  logic               w_win_hit;
  logic               w_lose_hit;
  logic [SCORE_W-1:0] w_win_inc;
  logic [SCORE_W-1:0] w_lose_inc;

  // Crossing detection done one bit wider so a large step cannot wrap past the boundary.
  assign w_step     = i_mode[0] ? ALT_EXT : {{WIDTH{1'b0}}, 1'b1};
  assign w_sum      = {1'b0, r_count} + w_step;
  assign w_win_hit  = (w_sum >= MAX_EXT);
  assign w_lose_hit = ({1'b0, r_count} <= w_step);
  assign w_win_inc  = r_win_count + {{(SCORE_W-1){1'b0}}, 1'b1};
  assign w_lose_inc = r_lose_count + {{(SCORE_W-1){1'b0}}, 1'b1};

  // Next-state and next-output computation for the game FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_win_nxt        = r_win_count;
    w_lose_nxt       = r_lose_count;
    w_win_pulse_nxt  = 1'b0;
    w_lose_pulse_nxt = 1'b0;
    w_gameover_nxt   = r_gameover;
    w_who_nxt        = r_who;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt    = S_RUN;
          w_count_nxt    = INIT_CNT;
          w_win_nxt      = {SCORE_W{1'b0}};
          w_lose_nxt     = {SCORE_W{1'b0}};
          w_gameover_nxt = 1'b0;
          w_who_nxt      = 2'b00;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        if (!i_en) begin
          w_count_nxt = r_count;
        end else if (i_init) begin
          w_count_nxt = i_load_value;
        end else if (!i_mode[1]) begin
          if (w_win_hit) begin
            w_count_nxt     = INIT_CNT;
            w_win_nxt       = w_win_inc;
            w_win_pulse_nxt = 1'b1;
            if (w_win_inc == WIN_LIM) begin
              w_state_nxt    = S_DONE;
              w_gameover_nxt = 1'b1;
              w_who_nxt      = 2'b10;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_count_nxt = w_sum[WIDTH-1:0];
          end
        end else begin
          if (w_lose_hit) begin
            w_count_nxt      = INIT_CNT;
            w_lose_nxt       = w_lose_inc;
            w_lose_pulse_nxt = 1'b1;
            if (w_lose_inc == LOSE_LIM) begin
              w_state_nxt    = S_DONE;
              w_gameover_nxt = 1'b1;
              w_who_nxt      = 2'b01;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_count_nxt = r_count - w_step[WIDTH-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_count      <= {WIDTH{1'b0}};
      r_win_count  <= {SCORE_W{1'b0}};
      r_lose_count <= {SCORE_W{1'b0}};
      r_win_pulse  <= 1'b0;
      r_lose_pulse <= 1'b0;
      r_gameover   <= 1'b0;
      r_who        <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_win_count  <= w_win_nxt;
      r_lose_count <= w_lose_nxt;
      r_win_pulse  <= w_win_pulse_nxt;
      r_lose_pulse <= w_lose_pulse_nxt;
      r_gameover   <= w_gameover_nxt;
      r_who        <= w_who_nxt;
    end
  end

  assign o_count      = r_count;
  assign o_win_count  = r_win_count;
  assign o_lose_count = r_lose_count;
  assign o_win_pulse  = r_win_pulse;
  assign o_lose_pulse = r_lose_pulse;
  assign o_gameover   = r_gameover;
  assign o_who        = r_who;

endmodule

// File: tb/tb_multi_mode_counter_gen2.sv
// Bench for multi_mode_counter_gen2: directed vector table followed by
// randomized traffic compared against an integer-level game model.
module tb_multi_mode_counter_gen2;

  localparam int W    = 4;
  localparam int SW   = 4;
  localparam int ALT  = 2;
  localparam int INIT = 1;
  localparam int WL   = 3;
  localparam int LL   = 3;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          en;
  logic          init;
  logic [W-1:0]  load_value;
  logic [1:0]    mode;
  logic [W-1:0]  count;
  logic [SW-1:0] win_count;
  logic [SW-1:0] lose_count;
  logic          win_pulse;
  logic          lose_pulse;
  logic          gameover;
  logic [1:0]    who;

  multi_mode_counter_gen2 #(
    .WIDTH(W), .SCORE_W(SW), .STEP_ALT(ALT), .INIT_VAL(INIT),
    .WIN_LIMIT(WL), .LOSE_LIMIT(LL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_init(init),
    .i_load_value(load_value), .i_mode(mode), .o_count(count),
    .o_win_count(win_count), .o_lose_count(lose_count),
    .o_win_pulse(win_pulse), .o_lose_pulse(lose_pulse),
    .o_gameover(gameover), .o_who(who)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        en;
    logic        ini;
    logic [3:0]  ld;
    logic [1:0]  md;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  // Model state: whether a game is running plus plain integer scores.
  bit         m_run;
  int         m_cnt, m_w, m_l;
  bit         m_wp, m_lp, m_go;
  logic [1:0] m_who;

  function automatic logic [16:0] pk(int c, int w, int l, bit wp, bit lp, bit go, logic [1:0] wh);
    return {4'(c), 4'(w), 4'(l), wp, lp, go, wh};
  endfunction

  function automatic void add(bit st, bit e, bit ini, int ld, int md,
                              int c, int w, int l, bit wp, bit lp, bit go, logic [1:0] wh);
    vec_t v;
    v.st = st; v.en = e; v.ini = ini; v.ld = 4'(ld); v.md = 2'(md);
    v.exp = pk(c, w, l, wp, lp, go, wh);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {count, win_count, lose_count, win_pulse, lose_pulse, gameover, who};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got cnt=%0d win=%0d lose=%0d wp=%b lp=%b go=%b who=%b, expected cnt=%0d win=%0d lose=%0d wp=%b lp=%b go=%b who=%b",
               name, act[16:13], act[12:9], act[8:5], act[4], act[3], act[2], act[1:0],
               exp[16:13], exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic drive(input bit st, input bit e, input bit ini, input logic [3:0] ld, input logic [1:0] md);
    @(negedge clk);
    start = st; en = e; init = ini; load_value = ld; mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_w = 0; m_l = 0;
    m_wp = 1'b0; m_lp = 1'b0; m_go = 1'b0; m_who = 2'b00;
  endtask

  task automatic model_step(input bit st, input bit e, input bit ini, input int ld, input logic [1:0] md);
    int s;
    m_wp = 1'b0;
    m_lp = 1'b0;
    s = md[0] ? ALT : 1;
    if (!m_run) begin
      if (st) begin
        m_run = 1'b1; m_go = 1'b0; m_who = 2'b00;
        m_cnt = INIT; m_w = 0; m_l = 0;
      end
    end else if (e) begin
      if (ini) begin
        m_cnt = ld;
      end else if (!md[1]) begin
        if (m_cnt + s >= MAXV) begin
          m_cnt = INIT; m_w++; m_wp = 1'b1;
          if (m_w == WL) begin m_run = 1'b0; m_go = 1'b1; m_who = 2'b10; end
        end else begin
          m_cnt = m_cnt + s;
        end
      end else begin
        if (m_cnt <= s) begin
          m_cnt = INIT; m_l++; m_lp = 1'b1;
          if (m_l == LL) begin m_run = 1'b0; m_go = 1'b1; m_who = 2'b01; end
        end else begin
          m_cnt = m_cnt - s;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; init = 1'b0; load_value = '0; mode = 2'b00;

    add(1,0,0,0,0, 1,0,0,0,0,0,2'b00);
    for (int k = 0; k < 13; k++) add(0,1,0,0,0, 2+k,0,0,0,0,0,2'b00);
    add(0,1,0,0,0, 1,1,0,1,0,0,2'b00);
    add(0,1,1,13,0, 13,1,0,0,0,0,2'b00);
    add(0,1,0,0,1, 1,2,0,1,0,0,2'b00);
    add(0,1,0,0,3, 1,2,1,0,1,0,2'b00);
    add(0,1,1,3,2, 3,2,1,0,0,0,2'b00);
    add(0,1,0,0,2, 2,2,1,0,0,0,2'b00);
    add(0,1,0,0,2, 1,2,1,0,0,0,2'b00);
    add(0,1,0,0,2, 1,2,2,0,1,0,2'b00);
    for (int k = 0; k < 5; k++) add(0,0,1,9,0, 1,2,2,0,0,0,2'b00);
    add(0,1,1,14,1, 14,2,2,0,0,0,2'b00);
    add(0,1,0,0,1, 1,3,2,1,0,1,2'b10);
    add(0,1,0,0,0, 1,3,2,0,0,1,2'b10);
    add(0,1,1,5,0, 1,3,2,0,0,1,2'b10);
    add(1,0,0,0,0, 1,0,0,0,0,0,2'b00);
    add(1,1,0,0,0, 2,0,0,0,0,0,2'b00);
    add(1,1,0,0,0, 3,0,0,0,0,0,2'b00);
    add(0,1,0,0,3, 1,0,0,0,0,0,2'b00);
    add(0,1,0,0,3, 1,0,1,0,1,0,2'b00);
    add(0,1,0,0,3, 1,0,2,0,1,0,2'b00);
    add(0,1,0,0,3, 1,0,3,0,1,1,2'b01);
    add(0,1,1,7,0, 1,0,3,0,0,1,2'b01);
    add(1,1,0,0,0, 1,0,0,0,0,0,2'b00);
    add(0,1,1,15,0, 15,0,0,0,0,0,2'b00);
    add(0,1,0,0,0, 1,1,0,1,0,0,2'b00);
    add(0,1,1,0,0, 0,1,0,0,0,0,2'b00);
    add(0,1,0,0,1, 2,1,0,0,0,0,2'b00);

    #12;
    check("reset", pk(0,0,0,0,0,0,2'b00));
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].en, tbl[i].ini, tbl[i].ld, tbl[i].md);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset asserted between edges must clear outputs without waiting for a clock.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst", pk(0,0,0,0,0,0,2'b00));
    @(negedge clk);
    rst = 1'b0;
    drive(0,1,0,0,0);
    check("idle_after_rst", pk(0,0,0,0,0,0,2'b00));

    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit st, e, ini;
      logic [3:0] ld;
      logic [1:0] md;
      st  = ($urandom_range(0, 99) < 5);
      e   = ($urandom_range(0, 99) < 80);
      ini = ($urandom_range(0, 99) < 10);
      ld  = 4'($urandom_range(0, 15));
      md  = 2'($urandom_range(0, 3));
      model_step(st, e, ini, int'(ld), md);
      drive(st, e, ini, ld, md);
      check("random", pk(m_cnt, m_w, m_l, m_wp, m_lp, m_go, m_who));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
